// File: rtl/huffman_enc_tx.sv
// Serial Huffman encoder: replays a symbol's prefix code as one-cycle pulses on two bit lines.
// Optional err_o pulse for illegal symbols is built when HUFFMAN_ENC_ERR_EN is defined.
module huffman_enc_tx #(
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sym_valid_i,
    input  logic [2:0] sym_i,
    output logic       sym_ready_o,
    output logic       bit_0_o,
    output logic       bit_1_o,
    output logic       busy_o
`ifdef HUFFMAN_ENC_ERR_EN
    ,
    output logic       err_o
`endif
);

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t     state_q, state_d;
    logic [2:0] shift_q, shift_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] gap_q, gap_d;
    logic       bit0_q, bit0_d;
    logic       bit1_q, bit1_d;
    logic       busy_q, busy_d;
    logic       accept;
    logic [5:0] entry;

    // Returns {legal, length-1, left-aligned code}.
    function automatic logic [5:0] code_lookup(input logic [2:0] sym);
        case (sym)
            3'd1:    code_lookup = {1'b1, 2'd2, 3'b000};
            3'd2:    code_lookup = {1'b1, 2'd2, 3'b001};
            3'd3:    code_lookup = {1'b1, 2'd1, 3'b010};
            3'd4:    code_lookup = {1'b1, 2'd1, 3'b100};
            3'd5:    code_lookup = {1'b1, 2'd2, 3'b110};
            3'd6:    code_lookup = {1'b1, 2'd2, 3'b111};
            default: code_lookup = 6'd0;
        endcase
    endfunction

    assign sym_ready_o = (state_q == IDLE);
    assign accept      = sym_valid_i && sym_ready_o;
    assign entry       = code_lookup(sym_i);

    // The first bit is registered at the accept edge itself so it appears in the next cycle;
    // cnt_q therefore holds the bits still to come after the one currently shown.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        bit0_d  = 1'b0;
        bit1_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && entry[5]) begin
                    state_d = EMIT;
                    bit1_d  = entry[2];
                    bit0_d  = ~entry[2];
                    shift_d = {entry[1:0], 1'b0};
                    cnt_d   = entry[4:3];
                end
            end
            EMIT: begin
                if (GAP_CYCLES > 0) begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end else if (cnt_q != 2'd0) begin
                    bit1_d  = shift_q[2];
                    bit0_d  = ~shift_q[2];
                    shift_d = {shift_q[1:0], 1'b0};
                    cnt_d   = cnt_q - 2'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                end else if (cnt_q != 2'd0) begin
                    state_d = EMIT;
                    bit1_d  = shift_q[2];
                    bit0_d  = ~shift_q[2];
                    shift_d = {shift_q[1:0], 1'b0};
                    cnt_d   = cnt_q - 2'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            shift_q <= 3'd0;
            cnt_q   <= 2'd0;
            gap_q   <= 4'd0;
            bit0_q  <= 1'b0;
            bit1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            bit0_q  <= bit0_d;
            bit1_q  <= bit1_d;
            busy_q  <= busy_d;
        end
    end

    assign bit_0_o = bit0_q;
    assign bit_1_o = bit1_q;
    assign busy_o  = busy_q;

`ifdef HUFFMAN_ENC_ERR_EN
    logic err_q, err_d;

    assign err_d = accept && !entry[5];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_huffman_enc_tx.sv
// Directed bench for huffman_enc_tx: one instance with a one-cycle gap, one with no gap.
module tb_huffman_enc_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v1 = 1'b0, v0 = 1'b0;
    logic [2:0] s1 = 3'd0, s0 = 3'd0;
    logic       rdy1, b01, b11, busy1;
    logic       rdy0, b00, b10, busy0;
`ifdef HUFFMAN_ENC_ERR_EN
    logic       err1, err0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    huffman_enc_tx #(.GAP_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .sym_valid_i(v1), .sym_i(s1),
        .sym_ready_o(rdy1), .bit_0_o(b01), .bit_1_o(b11), .busy_o(busy1)
`ifdef HUFFMAN_ENC_ERR_EN
        , .err_o(err1)
`endif
    );

    huffman_enc_tx #(.GAP_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .sym_valid_i(v0), .sym_i(s0),
        .sym_ready_o(rdy0), .bit_0_o(b00), .bit_1_o(b10), .busy_o(busy0)
`ifdef HUFFMAN_ENC_ERR_EN
        , .err_o(err0)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference code table: returns {length, left-aligned code}.
    function automatic logic [4:0] ref_code(input int s);
        case (s)
            1: ref_code = {2'd3, 3'b000};
            2: ref_code = {2'd3, 3'b001};
            3: ref_code = {2'd2, 3'b010};
            4: ref_code = {2'd2, 3'b100};
            5: ref_code = {2'd3, 3'b110};
            6: ref_code = {2'd3, 3'b111};
            default: ref_code = 5'd0;
        endcase
    endfunction

    // Decoder model: maps received length and bits (first bit in MSB of the collected value).
    function automatic int decode(input int len, input logic [2:0] bits);
        decode = 0;
        if (len == 2 && bits[1:0] == 2'b01) decode = 3;
        if (len == 2 && bits[1:0] == 2'b10) decode = 4;
        if (len == 3 && bits == 3'b000) decode = 1;
        if (len == 3 && bits == 3'b001) decode = 2;
        if (len == 3 && bits == 3'b110) decode = 5;
        if (len == 3 && bits == 3'b111) decode = 6;
    endfunction

    initial begin
        logic [7:0] e_b1;
        logic [7:0] e_b0;
        logic [7:0] e_rdy;
        logic [2:0] got;
        logic [4:0] rc;
        int         nb;
        int         cyc;

        // Reset held for three cycles, then released
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_rdy1", rdy1, 1);
        chk("rst_busy1", busy1, 0);
        chk("rst_bits1", {b11, b01}, 0);
        chk("rst_rdy0", rdy0, 1);
        chk("rst_bits0", {b10, b00}, 0);
`ifdef HUFFMAN_ENC_ERR_EN
        chk("rst_err1", err1, 0);
`endif
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_quiet", {b11, b01, b10, b00, busy1, busy0}, 0);
        end

        // Symbol 3 (01) with one gap cycle
        v1 = 1'b1; s1 = 3'd3;
        tick();
        v1 = 1'b0; s1 = 3'd6;
        chk("s3_t1_bits", {b11, b01}, 2'b01);
        chk("s3_t1_busy", busy1, 1);
        chk("s3_t1_rdy", rdy1, 0);
        tick();
        chk("s3_t2_bits", {b11, b01}, 2'b00);
        chk("s3_t2_busy", busy1, 1);
        tick();
        chk("s3_t3_bits", {b11, b01}, 2'b10);
        tick();
        chk("s3_t4_bits", {b11, b01}, 2'b00);
        chk("s3_t4_busy", busy1, 1);
        chk("s3_t4_rdy", rdy1, 0);
        tick();
        chk("s3_t5_rdy", rdy1, 1);
        chk("s3_t5_busy", busy1, 0);

        // No gap, valid held: 6 then 1
        e_b1  = 8'b1110_0000;
        e_b0  = 8'b0000_1110;
        e_rdy = 8'b0001_0001;
        v0 = 1'b1; s0 = 3'd6;
        tick();
        s0 = 3'd1;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) v0 = 1'b0;
            chk("b2b_bit1", b10, e_b1[7-k]);
            chk("b2b_bit0", b00, e_b0[7-k]);
            chk("b2b_rdy", rdy0, e_rdy[7-k]);
            chk("b2b_excl", b10 & b00, 0);
            tick();
        end

        // Loop-back of symbols 1..6 through the decoder model
        for (int s = 1; s <= 6; s++) begin
            v1 = 1'b1; s1 = 3'(s);
            tick();
            v1 = 1'b0;
            got = 3'd0; nb = 0; cyc = 0;
            while (!rdy1 && cyc < 20) begin
                if (b11 & b01) chk("lb_excl", 1, 0);
                if (b11 | b01) begin
                    got = {got[1:0], b11};
                    nb++;
                end
                tick();
                cyc++;
            end
            chk("lb_timeout", cyc < 20, 1);
            rc = ref_code(s);
            chk("lb_len", nb, rc[4:3]);
            chk("lb_cycles", cyc, 32'(rc[4:3]) * 2);
            chk("lb_decode", decode(nb, got), s);
        end

        // Illegal symbols 7 and 0 are dropped
        for (int j = 0; j < 2; j++) begin
            v1 = 1'b1; s1 = (j == 0) ? 3'd7 : 3'd0;
            tick();
            v1 = 1'b0;
            chk("ill_rdy", rdy1, 1);
            chk("ill_busy", busy1, 0);
            chk("ill_bits", {b11, b01}, 0);
`ifdef HUFFMAN_ENC_ERR_EN
            chk("ill_err", err1, 1);
`endif
            tick();
            chk("ill_quiet", {b11, b01, busy1}, 0);
`ifdef HUFFMAN_ENC_ERR_EN
            chk("ill_err_clr", err1, 0);
`endif
        end

        // Reset after the first pulse of symbol 5
        v1 = 1'b1; s1 = 3'd5;
        tick();
        v1 = 1'b0;
        chk("rst5_first", {b11, b01}, 2'b10);
        rst = 1'b1;
        #2;
        chk("rst5_bits", {b11, b01}, 0);
        chk("rst5_busy", busy1, 0);
        chk("rst5_rdy", rdy1, 1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst5_quiet", {b11, b01, busy1}, 0);
        end

        // Symbol 4 (10) after reset release
        v1 = 1'b1; s1 = 3'd4;
        tick();
        v1 = 1'b0;
        chk("s4_t1", {b11, b01}, 2'b10);
        tick();
        chk("s4_t2", {b11, b01}, 2'b00);
        tick();
        chk("s4_t3", {b11, b01}, 2'b01);
        tick();
        chk("s4_t4", {b11, b01, busy1}, 3'b001);
        tick();
        chk("s4_t5_rdy", rdy1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
